rs_syndrome: RTL
================

// Module: rs_syndrome
// PURPOSE
//  First stage of the RS decoder: computes the ROOTS_NUM syndromes of a received word,
//  BUS_WIDTH_IN_SYMB symbols per beat. Uses per-lane Horner accumulation in GF(2^SYMB_WIDTH).
//  Feeds the Berlekamp-Massey stage.
//  A zero syndrome set means the word has no detectable error.
// PARAMETERS (all taken from gf_pkg, no local overrides)
//  SYMB_WIDTH         8    symbol width in bits; field polynomial POLY=285
//  N_LEN              255  symbols per codeword
//  ROOTS_NUM          16   N_LEN-K_LEN; number of syndromes produced
//  BUS_WIDTH_IN_SYMB  4    symbol lanes per input beat
//  FIRST_ROOT         1    syndrome j is evaluated at alpha^((FIRST_ROOT+j) % FIELD_CHARAC)
// PORTS
//  clk       in   1                            clock, rising edge
//  rst       in   1                            asynchronous, active-high reset
//  s_valid   in   1                            input beat valid
//  s_ready   out  1                            block can accept a beat
//  s_data    in   BUS_WIDTH_IN_SYMB*SYMB_WIDTH lane k = bits [k*SYMB_WIDTH +: SYMB_WIDTH]
//  s_keep    in   BUS_WIDTH_IN_SYMB            lane-valid mask, contiguous from lane 0
//  s_last    in   1                            beat carries the last symbol of the codeword
//  m_valid   out  1                            syndrome set valid
//  m_ready   in   1                            consumer accepts the syndrome set
//  m_synd    out  ROOTS_NUM*SYMB_WIDTH         S_j = bits [j*SYMB_WIDTH +: SYMB_WIDTH]
//  m_nz      out  1                            OR of all S_j != 0 (error present)
//  m_len_err out  1                            symbol count != N_LEN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: every accumulator is 0; m_valid, m_synd, m_nz, m_len_err are 0; s_ready is 1.
//  - Symbol order: lane 0 of the first beat is r_{N_LEN-1} (highest degree). Higher lanes
//    and later beats carry lower degrees.
//  - Beat transfer when s_valid && s_ready. For each valid lane k, in ascending order,
//    within one cycle: acc_j = gf_mult(acc_j, root_j) ^ lane_k. Invalid lanes are bypassed.
//  - Accumulators start at 0 for each codeword. A beat with s_last uses the accumulator
//    zero value as its Horner seed for the next word. The accumulator is cleared the same
//    cycle the result is captured.
//  - On an s_last transfer: the final acc values are registered into m_synd; m_nz and
//    m_len_err are registered the same cycle; m_valid rises on the next cycle. Latency from
//    the last beat to m_valid is 1 clk.
//  - m_valid, m_synd, m_nz and m_len_err hold stable until m_valid && m_ready. m_valid then
//    drops on the next cycle unless a new s_last transfer occurs in the same cycle, which
//    reloads the outputs with m_valid held at 1.
//  - s_ready = !m_valid || m_ready. This stalls input only while a result is pending and
//    not consumed.
//  - s_keep == 0 with s_valid: the beat is accepted and leaves the accumulators unchanged;
//    s_last is still honoured.
//  - Non-contiguous s_keep is illegal; behaviour is undefined. The bench asserts on it.
//  - rst asserted mid-codeword: the partial word is discarded and no result is emitted.
//  - Width rule: all GF arithmetic is SYMB_WIDTH bits; the symbol counter is
//    $clog2(N_LEN+BUS_WIDTH_IN_SYMB+1) bits and saturates at its maximum.
// CONFIGURATION
//  - `RS_SYND_LEN_CHECK_EN defined: a symbol counter adds popcount(s_keep) per transfer
//    and clears after s_last. m_len_err = (count incl. last beat != N_LEN).
//  - `RS_SYND_LEN_CHECK_EN undefined: no counter is built; m_len_err is tied to 0.
// STRUCTURE
//  - gf_pkg additions: typedef symb_t synd_t [ROOTS_NUM-1:0];
//    function synd_t gen_synd_roots() returning alpha_to_symb((FIRST_ROOT+j)%FIELD_CHARAC).
//  - Sub-module rs_synd_cell: one per syndrome (generate loop). It holds acc_j and the
//    lane-chained Horner step with root_j as a constant parameter.
//  - Top level holds the handshake, the output register, the OR-reduce and the optional
//    counter.
// TESTING
//  1. All-zero 255-symbol word (63 full beats, last beat s_keep=4'b0111) ->
//     m_synd all 0, m_nz=0, m_len_err=0.
//  2. Single error 0x01 at r_254 (lane 0 of beat 0), rest zero ->
//     S_0=0x8E (alpha^254), S_j=alpha^(254*(j+1)), m_nz=1.
//  3. Valid RS(255,239) codeword from the encoder model -> all S_j=0.
//     The same word with 8 random symbol errors -> matches the gf_pkg reference model.
//  4. Back-to-back words with m_ready held 0 for 10 cycles -> s_ready=0 after the first
//     result; the second result is intact; no beat is lost or duplicated.
//  5. rst pulsed after 20 beats of a word, then a clean zero word ->
//     exactly one result, all zero.
//  6. With `RS_SYND_LEN_CHECK_EN, a 254-symbol word (last s_keep=4'b0011) -> m_len_err=1.
//     Without the macro -> m_len_err=0.

Source files
------------

// File: rtl/rs_syndrome_pkg.sv
// Galois-field package for the RS syndrome stage.
// Holds the code parameters, symbol and syndrome-vector types, and the GF(2^8)
// helpers used to build the constant roots of the syndrome cells.
// Optional feature macro used by the top level: RS_SYND_LEN_CHECK_EN.
package rs_syndrome_pkg;

    localparam int SYMB_WIDTH        = 8;
    localparam int N_LEN             = 255;
    localparam int ROOTS_NUM         = 16;
    localparam int BUS_WIDTH_IN_SYMB = 4;
    localparam int FIRST_ROOT        = 1;
    localparam int FIELD_CHARAC      = (1 << SYMB_WIDTH) - 1;
    localparam int BUS_DATA_W        = BUS_WIDTH_IN_SYMB * SYMB_WIDTH;

    // Field polynomial x^8 + x^4 + x^3 + x^2 + 1 (285).
    localparam logic [SYMB_WIDTH:0] POLY = 9'd285;

    // Symbol counter wide enough for a full word plus one extra beat.
    localparam int CNT_W = $clog2(N_LEN + BUS_WIDTH_IN_SYMB + 1);
    localparam int KC_W  = $clog2(BUS_WIDTH_IN_SYMB + 1);

    typedef logic [SYMB_WIDTH-1:0] symb_t;
    // Packed so that S_j sits at bits [j*SYMB_WIDTH +: SYMB_WIDTH].
    typedef symb_t [ROOTS_NUM-1:0] synd_t;

    // Shift-and-add multiply; with one constant operand this folds into an XOR network.
    function automatic symb_t gf_mult(input symb_t a, input symb_t b);
        symb_t p;
        symb_t x;
        p = '0;
        x = a;
        for (int i = 0; i < SYMB_WIDTH; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            if (x[SYMB_WIDTH-1]) begin
                x = (x << 1) ^ POLY[SYMB_WIDTH-1:0];
            end else begin
                x = x << 1;
            end
        end
        return p;
    endfunction

    function automatic symb_t alpha_to_symb(input int e);
        symb_t v;
        v = symb_t'(1);
        for (int i = 0; i < e; i++) begin
            v = gf_mult(v, symb_t'(2));
        end
        return v;
    endfunction

    function automatic synd_t gen_synd_roots();
        synd_t r;
        for (int j = 0; j < ROOTS_NUM; j++) begin
            r[j] = alpha_to_symb((FIRST_ROOT + j) % FIELD_CHARAC);
        end
        return r;
    endfunction

    function automatic logic [KC_W-1:0] keep_popcount(input logic [BUS_WIDTH_IN_SYMB-1:0] keep);
        logic [KC_W-1:0] c;
        c = '0;
        for (int i = 0; i < BUS_WIDTH_IN_SYMB; i++) begin
            c = c + {{(KC_W-1){1'b0}}, keep[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/rs_syndrome_if.sv
// Stream interface of the RS syndrome stage.
// s_*     : symbol input stream (valid/ready, lane data, lane keep mask, end-of-word).
// m_*     : syndrome-set output (valid/ready, syndrome vector, error flag, length flag).
// slave   : the syndrome block side.  master : the producer/consumer side.
interface rs_syndrome_if;
    import rs_syndrome_pkg::*;

    logic                          s_valid;
    logic                          s_ready;
    logic [BUS_DATA_W-1:0]         s_data;
    logic [BUS_WIDTH_IN_SYMB-1:0]  s_keep;
    logic                          s_last;
    logic                          m_valid;
    logic                          m_ready;
    synd_t                         m_synd;
    logic                          m_nz;
    logic                          m_len_err;

    modport slave (
        input  s_valid, s_data, s_keep, s_last, m_ready,
        output s_ready, m_valid, m_synd, m_nz, m_len_err
    );

    modport master (
        output s_valid, s_data, s_keep, s_last, m_ready,
        input  s_ready, m_valid, m_synd, m_nz, m_len_err
    );

endinterface

// File: rtl/rs_synd_cell.sv
// One syndrome accumulator: Horner evaluation of the received word at a fixed root.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   beat_en    a beat is transferred this cycle
//   clear      the transferred beat ends the word; accumulator restarts at 0
//   data, keep lane symbols and contiguous lane-valid mask of the beat
//   synd_next  accumulator value after folding in this beat's valid lanes
module rs_synd_cell
    import rs_syndrome_pkg::*;
#(
    parameter symb_t ROOT = 8'h02
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          beat_en,
    input  logic                          clear,
    input  logic [BUS_DATA_W-1:0]         data,
    input  logic [BUS_WIDTH_IN_SYMB-1:0]  keep,
    output symb_t                         synd_next
);

    symb_t acc_q;
    symb_t acc_d;
    symb_t chain;

    // Lane 0 holds the highest-degree symbol of the beat, so lanes are folded in
    // ascending order; masked lanes pass the running value through untouched.
    always_comb begin
        chain = acc_q;
        for (int k = 0; k < BUS_WIDTH_IN_SYMB; k++) begin
            if (keep[k]) begin
                chain = gf_mult(chain, ROOT) ^ data[k*SYMB_WIDTH +: SYMB_WIDTH];
            end
        end
        acc_d = acc_q;
        if (beat_en) begin
            acc_d = clear ? '0 : chain;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign synd_next = chain;

endmodule

// File: rtl/rs_syndrome.sv
// RS(255,239) syndrome stage: computes ROOTS_NUM syndromes of a received word
// delivered BUS_WIDTH_IN_SYMB symbols per beat, first symbol = highest degree.
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-high reset; a partial word in flight is dropped
//   bus   rs_syndrome_if.slave: input stream s_* and syndrome output m_*
// Result is registered on the s_last transfer and held until m_valid && m_ready.
// Optional feature: define RS_SYND_LEN_CHECK_EN to build the symbol counter that
// drives m_len_err; otherwise m_len_err is constant 0.
module rs_syndrome
    import rs_syndrome_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    rs_syndrome_if.slave  bus
);

    localparam synd_t SYND_ROOTS = gen_synd_roots();

    logic  xfer;
    logic  last_xfer;
    synd_t synd_next;

    logic  m_valid_q, m_valid_d;
    synd_t m_synd_q,  m_synd_d;
    logic  m_nz_q,    m_nz_d;

    // Input is stalled only while a result is waiting and not being taken.
    assign bus.s_ready = !m_valid_q || bus.m_ready;
    assign xfer        = bus.s_valid && bus.s_ready;
    assign last_xfer   = xfer && bus.s_last;

    for (genvar j = 0; j < ROOTS_NUM; j++) begin : g_cell
        rs_synd_cell #(
            .ROOT (SYND_ROOTS[j])
        ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .beat_en   (xfer),
            .clear     (bus.s_last),
            .data      (bus.s_data),
            .keep      (bus.s_keep),
            .synd_next (synd_next[j])
        );
    end

    // A new result may overwrite the held one only in the cycle it is consumed,
    // which s_ready already guarantees; m_valid then simply stays high.
    always_comb begin
        m_valid_d = m_valid_q;
        m_synd_d  = m_synd_q;
        m_nz_d    = m_nz_q;
        if (last_xfer) begin
            m_valid_d = 1'b1;
            m_synd_d  = synd_next;
            m_nz_d    = |synd_next;
        end else if (m_valid_q && bus.m_ready) begin
            m_valid_d = 1'b0;
        end
    end

`ifdef RS_SYND_LEN_CHECK_EN
    localparam logic [CNT_W-1:0] N_LEN_CNT = N_LEN[CNT_W-1:0];

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   cnt_sum;
    logic [CNT_W-1:0] cnt_sat;
    logic             m_len_err_q, m_len_err_d;

    // Count includes the last beat; saturates so an overlong word cannot wrap
    // back onto N_LEN.
    always_comb begin
        cnt_sum     = {1'b0, cnt_q} + {{(CNT_W+1-KC_W){1'b0}}, keep_popcount(bus.s_keep)};
        cnt_sat     = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        cnt_d       = cnt_q;
        m_len_err_d = m_len_err_q;
        if (xfer) begin
            cnt_d = bus.s_last ? '0 : cnt_sat;
        end
        if (last_xfer) begin
            m_len_err_d = (cnt_sat != N_LEN_CNT);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q   <= 1'b0;
            m_synd_q    <= '0;
            m_nz_q      <= 1'b0;
`ifdef RS_SYND_LEN_CHECK_EN
            cnt_q       <= '0;
            m_len_err_q <= 1'b0;
`endif
        end else begin
            m_valid_q   <= m_valid_d;
            m_synd_q    <= m_synd_d;
            m_nz_q      <= m_nz_d;
`ifdef RS_SYND_LEN_CHECK_EN
            cnt_q       <= cnt_d;
            m_len_err_q <= m_len_err_d;
`endif
        end
    end

    assign bus.m_valid = m_valid_q;
    assign bus.m_synd  = m_synd_q;
    assign bus.m_nz    = m_nz_q;
`ifdef RS_SYND_LEN_CHECK_EN
    assign bus.m_len_err = m_len_err_q;
`else
    assign bus.m_len_err = 1'b0;
`endif

endmodule
